// File: rtl/swap_sequencer.sv
// Two-requester round-robin arbiter and sequencer for the register-file swap
// datapath. A granted command (addr_a, addr_b) is carried out in three steps:
//   TMP <= RF[a], RF[a] <= RF[b], RF[b] <= TMP
// The register file, temp register and write-data mux live outside this block.
// Completion is reported with a registered done pulse tagged with the requester id.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a command; arbitration is live, no datapath activity
// LOAD_T  | temp register loads RF[a_q]
// COPY_A  | RF[a_q] is written with RF[b_q]
// WRITE_B | RF[b_q] is written with the temp register; done follows next cycle

module swap_sequencer #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    input  logic [AW-1:0] req_addr_a0,
    input  logic [AW-1:0] req_addr_b0,
    input  logic [AW-1:0] req_addr_a1,
    input  logic [AW-1:0] req_addr_b1,
    output logic [1:0]    req_ready,
    output logic          busy,
    output logic [AW-1:0] rd_addr,
    output logic [AW-1:0] wr_addr,
    output logic          wr_en,
    output logic          wdata_sel,
    output logic          tmp_load,
    output logic          done,
    output logic          done_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_T  = 2'd1,
        COPY_A  = 2'd2,
        WRITE_B = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          last_grant;
    logic [AW-1:0] a_q;
    logic [AW-1:0] b_q;
    logic          id_q;

    logic [1:0]    grant;
    logic          accept;
    logic          grant_id;
    logic [AW-1:0] sel_a;
    logic [AW-1:0] sel_b;
    logic          noop;

    // Round-robin grant, only offered in IDLE and never while reset is held
    // (the reset term keeps req_ready low even though state is already IDLE).
    always_comb begin
        grant = 2'b00;
        if (rst && (state == IDLE)) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign grant_id  = grant[1];
    assign sel_a     = grant_id ? req_addr_a1 : req_addr_a0;
    assign sel_b     = grant_id ? req_addr_b1 : req_addr_b0;
    assign noop      = (sel_a == sel_b);
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore datapath decode from state and latched addresses.
    always_comb begin
        state_nxt = state;
        rd_addr   = '0;
        wr_addr   = '0;
        wr_en     = 1'b0;
        wdata_sel = 1'b0;
        tmp_load  = 1'b0;
        case (state)
            IDLE: begin
                // A command whose two addresses match needs no datapath work.
                if (accept && !noop) begin
                    state_nxt = LOAD_T;
                end
            end
            LOAD_T: begin
                rd_addr   = a_q;
                tmp_load  = 1'b1;
                state_nxt = COPY_A;
            end
            COPY_A: begin
                rd_addr   = b_q;
                wr_addr   = a_q;
                wr_en     = 1'b1;
                state_nxt = WRITE_B;
            end
            WRITE_B: begin
                wr_addr   = b_q;
                wr_en     = 1'b1;
                wdata_sel = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch and fairness pointer, captured only on the accept edge.
    // last_grant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            a_q        <= sel_a;
            b_q        <= sel_b;
            id_q       <= grant_id;
            last_grant <= grant_id;
        end
    end

    // Registered completion pulse: after WRITE_B, or one cycle after a no-op accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == WRITE_B) begin
                done    <= 1'b1;
                done_id <= id_q;
            end else if (accept && noop) begin
                done    <= 1'b1;
                done_id <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_swap_sequencer.sv
// Bench for swap_sequencer: drives the two requesters, models the external
// register file / temp register, and checks done ids through a queue of
// expected ids pushed at each accept.

module tb_swap_sequencer;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [AW-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]    req_ready;
    logic          busy;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          wdata_sel;
    logic          tmp_load;
    logic          done;
    logic          done_id;

    swap_sequencer #(.AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr_a0 (a0),
        .req_addr_b0 (b0),
        .req_addr_a1 (a1),
        .req_addr_b1 (b1),
        .req_ready   (req_ready),
        .busy        (busy),
        .rd_addr     (rd_addr),
        .wr_addr     (wr_addr),
        .wr_en       (wr_en),
        .wdata_sel   (wdata_sel),
        .tmp_load    (tmp_load),
        .done        (done),
        .done_id     (done_id)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic [7:0] rf [4];
    logic [7:0] rf_init [4];
    logic [7:0] tmp;
    logic       rf_load = 1'b0;

    logic exp_q [$];
    int   grant_log [$];
    int   acc_cyc [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // External datapath plus accept scoreboard.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_load) begin
            for (int i = 0; i < 4; i++) rf[i] <= rf_init[i];
        end else begin
            if (tmp_load) tmp <= rf[rd_addr];
            if (wr_en) rf[wr_addr] <= wdata_sel ? tmp : rf[rd_addr];
        end
        if (rst && ((req_valid & req_ready) != 2'b00)) begin
            exp_q.push_back(req_ready[1]);
            grant_log.push_back(int'(req_ready[1]));
            acc_cyc.push_back(cyc);
        end
    end

    // Done ids against the scoreboard; control strobe exclusivity every cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (done) begin
                if (exp_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_id_sb", 32'(done_id), 32'(exp_q.pop_front()));
            end
            chk("ctl_onehot", 32'(tmp_load) + 32'(wr_en), 32'(busy));
        end
    end

    task automatic load_rf(input logic [7:0] v0, v1, v2, v3);
        rf_init[0] = v0; rf_init[1] = v1; rf_init[2] = v2; rf_init[3] = v3;
        rf_load = 1'b1;
        @(negedge clk);
        rf_load = 1'b0;
    endtask

    task automatic check_rf(input string tag, input logic [7:0] v0, v1, v2, v3);
        chk({tag, "_rf0"}, 32'(rf[0]), 32'(v0));
        chk({tag, "_rf1"}, 32'(rf[1]), 32'(v1));
        chk({tag, "_rf2"}, 32'(rf[2]), 32'(v2));
        chk({tag, "_rf3"}, 32'(rf[3]), 32'(v3));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        #2;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = 2'b00;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [AW-1:0] ra0 [2];
    logic [AW-1:0] rb0 [2];
    logic [AW-1:0] ra1 [2];
    logic [AW-1:0] rb1 [2];

    initial begin
        int idx0, idx1, seen, n, base;

        // Reset state, with both requests asserted to show ready stays low.
        req_valid = 2'b11;
        #2;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_id", 32'(done_id), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_tmp_load", 32'(tmp_load), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b1;

        // Single swap.
        load_rf(10, 20, 30, 40);
        a0 = 1; b0 = 3; req_valid = 2'b01;
        #1 chk("s_ready", 32'(req_ready), 1);
        chk("s_busy0", 32'(busy), 0);
        @(negedge clk);
        chk("s_lt_busy", 32'(busy), 1);
        chk("s_lt_rd", 32'(rd_addr), 1);
        chk("s_lt_tmp", 32'(tmp_load), 1);
        chk("s_lt_wren", 32'(wr_en), 0);
        chk("s_lt_ready", 32'(req_ready), 0);
        req_valid = 2'b00;
        @(negedge clk);
        chk("s_ca_busy", 32'(busy), 1);
        chk("s_ca_rd", 32'(rd_addr), 3);
        chk("s_ca_wr", 32'(wr_addr), 1);
        chk("s_ca_wren", 32'(wr_en), 1);
        chk("s_ca_sel", 32'(wdata_sel), 0);
        @(negedge clk);
        chk("s_wb_busy", 32'(busy), 1);
        chk("s_wb_rd", 32'(rd_addr), 0);
        chk("s_wb_wr", 32'(wr_addr), 3);
        chk("s_wb_wren", 32'(wr_en), 1);
        chk("s_wb_sel", 32'(wdata_sel), 1);
        chk("s_wb_done", 32'(done), 0);
        @(negedge clk);
        chk("s_done", 32'(done), 1);
        chk("s_done_id", 32'(done_id), 0);
        chk("s_idle", 32'(busy), 0);
        check_rf("single", 10, 40, 30, 20);
        @(negedge clk);
        chk("s_done_low", 32'(done), 0);

        // Simultaneous requests right after reset: requester 0 first.
        do_reset();
        load_rf(10, 20, 30, 40);
        a0 = 0; b0 = 1; a1 = 2; b1 = 3; req_valid = 2'b11;
        #1 chk("sim_ready0", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b10;
        #1 chk("sim_ready_busy", 32'(req_ready), 0);
        repeat (3) @(negedge clk);
        chk("sim_done0", 32'(done), 1);
        chk("sim_done_id0", 32'(done_id), 0);
        #1 chk("sim_ready1", 32'(req_ready), 2);
        @(negedge clk);
        req_valid = 2'b00;
        chk("sim_busy1", 32'(busy), 1);
        repeat (3) @(negedge clk);
        chk("sim_done1", 32'(done), 1);
        chk("sim_done_id1", 32'(done_id), 1);
        check_rf("sim", 20, 10, 40, 30);

        // Round robin with both requesters holding two commands each.
        load_rf(1, 2, 3, 4);
        ra0[0] = 0; rb0[0] = 1; ra0[1] = 2; rb0[1] = 3;
        ra1[0] = 1; rb1[0] = 2; ra1[1] = 3; rb1[1] = 0;
        grant_log.delete();
        idx0 = 0; idx1 = 0; seen = 0; n = 0;
        while ((idx0 < 2 || idx1 < 2) && n < 60) begin
            req_valid = {idx1 < 2, idx0 < 2};
            a0 = ra0[idx0 < 2 ? idx0 : 1]; b0 = rb0[idx0 < 2 ? idx0 : 1];
            a1 = ra1[idx1 < 2 ? idx1 : 1]; b1 = rb1[idx1 < 2 ? idx1 : 1];
            @(negedge clk);
            n++;
            while (seen < grant_log.size()) begin
                if (grant_log[seen] == 0) idx0++;
                else idx1++;
                seen++;
            end
        end
        req_valid = 2'b00;
        chk("rr_timeout", 32'(n < 60), 1);
        chk("rr_count", grant_log.size(), 4);
        for (int i = 0; i < grant_log.size(); i++)
            chk($sformatf("rr_order%0d", i), grant_log[i], i % 2);
        drain(20);
        check_rf("rr", 1, 3, 4, 2);

        // No-op command from requester 1.
        @(negedge clk);
        a1 = 2; b1 = 2; req_valid = 2'b10;
        #1 chk("nop_ready", 32'(req_ready), 2);
        @(negedge clk);
        chk("nop_busy", 32'(busy), 0);
        chk("nop_done", 32'(done), 1);
        chk("nop_done_id", 32'(done_id), 1);
        chk("nop_wren", 32'(wr_en), 0);
        chk("nop_tmp", 32'(tmp_load), 0);
        req_valid = 2'b00;
        @(negedge clk);
        chk("nop_done_low", 32'(done), 0);
        chk("nop_busy2", 32'(busy), 0);
        check_rf("nop", 1, 3, 4, 2);

        // Reset during COPY_A (accept by requester 0 moves last_grant to 0).
        a0 = 2; b0 = 3; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        chk("mid_copy_wren", 32'(wr_en), 1);
        #1 rst = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 0);
        chk("mid_wren", 32'(wr_en), 0);
        chk("mid_rd", 32'(rd_addr), 0);
        chk("mid_wr", 32'(wr_addr), 0);
        chk("mid_tmp", 32'(tmp_load), 0);
        chk("mid_sel", 32'(wdata_sel), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_ready", 32'(req_ready), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_done", 32'(done), 0);
        end
        load_rf(10, 20, 30, 40);
        a0 = 0; b0 = 1; a1 = 2; b1 = 3; req_valid = 2'b11;
        #1 chk("mid_tie_ready", 32'(req_ready), 1);
        @(negedge clk);
        req_valid = 2'b10;
        repeat (3) @(negedge clk);
        chk("mid_rec_done", 32'(done), 1);
        chk("mid_rec_id", 32'(done_id), 0);
        check_rf("mid_rec", 20, 10, 30, 40);
        @(negedge clk);
        req_valid = 2'b00;
        drain(20);
        check_rf("mid_rec2", 20, 10, 40, 30);

        // Back-to-back from requester 0 with the same command.
        @(negedge clk);
        load_rf(10, 20, 30, 40);
        base = acc_cyc.size();
        a0 = 0; b0 = 3; req_valid = 2'b01;
        n = 0;
        while (acc_cyc.size() < base + 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 2'b00;
        chk("b2b_timeout", 32'(n < 20), 1);
        chk("b2b_count", acc_cyc.size() - base, 2);
        if (acc_cyc.size() >= base + 2)
            chk("b2b_spacing", acc_cyc[base + 1] - acc_cyc[base], 4);
        drain(20);
        check_rf("b2b", 10, 20, 30, 40);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
